// File: rtl/dma_priority_arbiter.sv
// Channel request arbiter for the 4-channel DMA controller: samples DREQ, applies polarity,
// mask and software requests, grants one channel (fixed or rotating) and drives DACK.
module dma_priority_arbiter #(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 1,
  localparam int CW         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [NUM_CH-1:0] DREQ,
  input  logic [7:0]        cmd_reg,
  input  logic [NUM_CH-1:0] mask_reg,
  input  logic [NUM_CH-1:0] sw_req,
  input  logic              idle_cycle,
  input  logic              dack_en,
  input  logic              cycle_done,
  output logic [NUM_CH-1:0] VALID_DREQ,
  output logic [CW-1:0]     grant_ch,
  output logic [NUM_CH-1:0] DACK
);

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANT   = 2'd1,
    ARB_RELEASE = 2'd2
  } arb_state_t;

  arb_state_t        state;
  logic [CW-1:0]     top_ptr;
  logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
  logic [NUM_CH-1:0] dreq_s;
  logic [NUM_CH-1:0] req_eff;
  logic [CW-1:0]     win_idx;
  logic [CW-1:0]     cand;
  logic              found;
  logic [CW-1:0]     next_ptr;
  logic [NUM_CH-1:0] dack_act;

  wire ctl_disable = cmd_reg[2];
  wire rotate      = cmd_reg[4];
  wire dreq_low    = cmd_reg[6];
  wire dack_high   = cmd_reg[7];

  logic unused_cmd;
  assign unused_cmd = ^{cmd_reg[5], cmd_reg[3], cmd_reg[1:0]};

  // Polarity is corrected before the synchronizer so reset leaves it "not requesting".
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= DREQ ^ {NUM_CH{dreq_low}};
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign dreq_s  = sync_q[SYNC_STAGES-1];
  assign req_eff = (dreq_s & ~mask_reg) | sw_req;

  always_comb begin
    win_idx = '0;
    cand    = '0;
    found   = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = CW'((int'(top_ptr) + k) % NUM_CH);
      if (!found && req_eff[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
  end

  assign next_ptr = (grant_ch == CW'(NUM_CH - 1)) ? '0 : grant_ch + 1'b1;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= ARB_IDLE;
      VALID_DREQ <= '0;
      grant_ch   <= '0;
      top_ptr    <= '0;
    end else begin
      if (!rotate) top_ptr <= '0;
      case (state)
        ARB_IDLE: begin
          if (!ctl_disable && idle_cycle && found) begin
            VALID_DREQ <= {{(NUM_CH-1){1'b0}}, 1'b1} << win_idx;
            grant_ch   <= win_idx;
            state      <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          if (cycle_done) begin
            VALID_DREQ <= '0;
            if (rotate) top_ptr <= next_ptr;
            state      <= ARB_RELEASE;
          end
        end
        ARB_RELEASE: state <= ARB_IDLE;
        default: begin
          state      <= ARB_IDLE;
          VALID_DREQ <= '0;
        end
      endcase
    end
  end

  assign dack_act = VALID_DREQ & {NUM_CH{dack_en}};
  assign DACK     = dack_high ? dack_act : ~dack_act;

  a_onehot: assert property (@(posedge CLK) disable iff (!RESET_N) $onehot0(VALID_DREQ));
  a_grant_state: assert property (@(posedge CLK) disable iff (!RESET_N)
    (VALID_DREQ != '0) |-> (state == ARB_GRANT));
  a_grant_idx: assert property (@(posedge CLK) disable iff (!RESET_N)
    (VALID_DREQ != '0) |-> VALID_DREQ[grant_ch]);

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Directed self-checking bench for dma_priority_arbiter (NUM_CH=4, SYNC_STAGES=1).
module tb_dma_priority_arbiter;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic [3:0] DREQ;
  logic [7:0] cmd_reg;
  logic [3:0] mask_reg;
  logic [3:0] sw_req;
  logic       idle_cycle;
  logic       dack_en;
  logic       cycle_done;
  logic [3:0] VALID_DREQ;
  logic [1:0] grant_ch;
  logic [3:0] DACK;

  int checks = 0;
  int errors = 0;

  dma_priority_arbiter #(.NUM_CH(4), .SYNC_STAGES(1)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .DREQ(DREQ), .cmd_reg(cmd_reg),
    .mask_reg(mask_reg), .sw_req(sw_req), .idle_cycle(idle_cycle),
    .dack_en(dack_en), .cycle_done(cycle_done), .VALID_DREQ(VALID_DREQ),
    .grant_ch(grant_ch), .DACK(DACK)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic done_pulse();
    cycle_done = 1'b1;
    tick();
    cycle_done = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] exp_rot [5];
    exp_rot[0] = 2'd0; exp_rot[1] = 2'd1; exp_rot[2] = 2'd2;
    exp_rot[3] = 2'd3; exp_rot[4] = 2'd0;

    RESET_N = 1'b0; DREQ = 4'h0; cmd_reg = 8'h00; mask_reg = 4'h0; sw_req = 4'h0;
    idle_cycle = 1'b0; dack_en = 1'b0; cycle_done = 1'b0;

    // reset state
    #12;
    chk("rst_valid", VALID_DREQ, 8'h0);
    chk("rst_dack", DACK, 8'hF);
    chk("rst_grant_ch", grant_ch, 8'h0);
    RESET_N = 1'b1;
    idle_cycle = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_valid", VALID_DREQ, 8'h0);
      chk("idle_dack", DACK, 8'hF);
    end
    chk("idle_grant_ch", grant_ch, 8'h0);

    // fixed priority, lowest index wins
    DREQ = 4'b1010;
    tick();
    chk("fix_lat1", VALID_DREQ, 8'h0);
    tick();
    chk("fix_valid", VALID_DREQ, 8'h2);
    chk("fix_grant_ch", grant_ch, 8'h1);
    chk("fix_dack_off", DACK, 8'hF);
    dack_en = 1'b1;
    #1;
    chk("fix_dack_on", DACK, 8'hD);
    done_pulse();
    chk("fix_release", VALID_DREQ, 8'h0);
    chk("fix_release_dack", DACK, 8'hF);
    tick();
    chk("fix_idle_gap", VALID_DREQ, 8'h0);
    tick();
    chk("fix_regrant", VALID_DREQ, 8'h2);
    dack_en = 1'b0;
    DREQ = 4'h0;
    done_pulse();
    tick();

    // rotating priority
    cmd_reg = 8'h10;
    DREQ = 4'hF;
    tick();
    tick();
    chk("rot_grant0", grant_ch, {6'd0, exp_rot[0]});
    for (int r = 1; r < 5; r++) begin
      done_pulse();
      chk("rot_release", VALID_DREQ, 8'h0);
      tick();
      tick();
      chk("rot_grant", grant_ch, {6'd0, exp_rot[r]});
      chk("rot_valid", VALID_DREQ, 8'h1 << exp_rot[r]);
    end
    cmd_reg = 8'h00;
    DREQ = 4'h0;
    done_pulse();
    tick();

    // polarity, mask and software request
    cmd_reg = 8'hC0;
    DREQ = 4'b1110;
    mask_reg = 4'b0001;
    sw_req = 4'b0100;
    tick();
    chk("pol_valid", VALID_DREQ, 8'h4);
    chk("pol_grant_ch", grant_ch, 8'h2);
    chk("pol_dack_off", DACK, 8'h0);
    dack_en = 1'b1;
    #1;
    chk("pol_dack_on", DACK, 8'h4);
    dack_en = 1'b0;
    sw_req = 4'h0;
    DREQ = 4'hF;
    done_pulse();
    tick();
    tick();
    chk("pol_masked_idle", VALID_DREQ, 8'h0);
    cmd_reg = 8'h00;
    mask_reg = 4'h0;
    DREQ = 4'h0;
    tick();

    // no preemption, then disable
    DREQ = 4'b1000;
    tick();
    tick();
    chk("np_valid", VALID_DREQ, 8'h8);
    DREQ = 4'b1001;
    cmd_reg = 8'h04;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("np_hold_valid", VALID_DREQ, 8'h8);
      chk("np_hold_ch", grant_ch, 8'h3);
    end
    done_pulse();
    for (int i = 0; i < 4; i++) begin
      chk("dis_no_grant", VALID_DREQ, 8'h0);
      tick();
    end
    cmd_reg = 8'h00;
    tick();
    chk("reen_grant", VALID_DREQ, 8'h1);
    chk("reen_grant_ch", grant_ch, 8'h0);

    // async reset mid-grant
    dack_en = 1'b1;
    #1;
    chk("ar_dack_pre", DACK, 8'hE);
    #1;
    RESET_N = 1'b0;
    #1;
    chk("ar_valid", VALID_DREQ, 8'h0);
    chk("ar_dack", DACK, 8'hF);
    chk("ar_grant_ch", grant_ch, 8'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dma_priority_arbiter.md
Name: dma_priority_arbiter

Overview:
- Channel request arbiter for the 4-channel DMA controller.
- Samples the DREQ pins and applies sense polarity, the mask register and software requests.
- Picks one channel by fixed or rotating priority and presents it to the timing-control FSM as a one-hot VALID_DREQ.
- Drives the DACK pins for the granted channel and holds the grant, without preemption, until the timing FSM reports the transfer cycle complete.

Parameters:
- NUM_CH, 4, number of DMA channels; all per-channel vectors are NUM_CH wide.
- SYNC_STAGES, 1, number of DREQ sampling flops (1 or 2).

Ports:
- CLK  in  1  controller clock; all state updates on the rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- DREQ  in  NUM_CH  raw request pins.
- cmd_reg  in  8  command register. Bit2 = controller disable. Bit4 = rotating priority. Bit6 = DREQ active-low. Bit7 = DACK active-high.
- mask_reg  in  NUM_CH  1 = channel hardware request masked.
- sw_req  in  NUM_CH  software request bits; not subject to the mask or the synchronizer.
- idle_cycle  in  1  high while the timing FSM is in its idle state.
- dack_en  in  1  high while the timing FSM is in an active transfer state.
- cycle_done  in  1  one-CLK pulse at the end of a transfer (S4, or EOP abort).
- VALID_DREQ  out  NUM_CH  registered one-hot grant to the timing FSM; all-zero = no grant.
- grant_ch  out  clog2(NUM_CH)  registered index of the current or last grant.
- DACK  out  NUM_CH  acknowledge pins.

Behaviour:
- Reset (async assert, sync release):
  - state=ARB_IDLE; VALID_DREQ=0; grant_ch=0; top_ptr=0.
  - Sync flops cleared to the "not requesting" level after polarity correction.
  - DACK is all-inactive (~cmd_reg[7] on every bit).
- Sampling:
  - dreq_s is the output of SYNC_STAGES flops fed by DREQ XOR {NUM_CH{cmd_reg[6]}}.
  - req_eff = (dreq_s & ~mask_reg) | sw_req, combinational.
- Priority:
  - Fixed mode (cmd_reg[4]=0): lowest index wins; top_ptr is forced to 0 every cycle.
  - Rotating mode: search starts at top_ptr and wraps modulo NUM_CH; the first set bit of req_eff wins.
- FSM:
  - ARB_IDLE: if cmd_reg[2]=0, idle_cycle=1 and |req_eff, then register the winner into VALID_DREQ (one-hot) and grant_ch, and go to ARB_GRANT. Otherwise stay; cycle_done is ignored in this state.
  - ARB_GRANT: VALID_DREQ and grant_ch are frozen. Changes on DREQ, mask_reg, sw_req or cmd_reg[2] have no effect. On cycle_done, clear VALID_DREQ; if cmd_reg[4]=1, top_ptr <= (grant_ch+1) mod NUM_CH; go to ARB_RELEASE.
  - ARB_RELEASE: exactly one cycle with VALID_DREQ=0, then ARB_IDLE. This guarantees at least one cycle with no grant between back-to-back transfers.
- DACK:
  - Combinational: DACK[i] = (VALID_DREQ[i] & dack_en) ? cmd_reg[7] : ~cmd_reg[7].
  - At most one DACK bit is active at any time.
  - DACK stays inactive whenever VALID_DREQ=0, even if dack_en=1.
- Latency (SYNC_STAGES=1): DREQ is sampled at edge n; VALID_DREQ is high after edge n+1 if ARB_IDLE and idle_cycle hold at that edge. Each extra sync stage adds one cycle. sw_req grants after the first qualifying edge.
- Simultaneous events:
  - cycle_done together with new requests: release first; a new grant is possible no earlier than 2 edges later.
  - Controller disable set mid-grant: the transfer completes, then no new grant while cmd_reg[2]=1.
  - Mode switch rotating→fixed mid-grant: top_ptr is forced to 0 and is not advanced at cycle_done.
  - Reset mid-grant: VALID_DREQ and DACK go inactive immediately (asynchronous).
- Invariants (assertions): VALID_DREQ is one-hot or zero; VALID_DREQ is nonzero only in ARB_GRANT; grant_ch equals the index of VALID_DREQ whenever VALID_DREQ is nonzero.

Test Plan:
- Reset state: with RESET_N low, VALID_DREQ=0, DACK=4'hF (cmd_reg=0x00), grant_ch=0. After release with no requests, these stay unchanged for 10 cycles.
- Fixed priority, SYNC_STAGES=1: DREQ=4'b1010, mask=0, idle_cycle=1 → VALID_DREQ=4'b0010 two edges later. dack_en=1 → DACK=4'b1101. cycle_done → one zero cycle, then VALID_DREQ=4'b0010 again.
- Rotating priority (cmd_reg=0x10): DREQ=4'hF held for four grant/cycle_done rounds → grants are ch0, ch1, ch2, ch3, ch0.
- Polarity and mask (cmd_reg=0xC0): DREQ=4'b1110 (ch0 requesting), mask_reg=4'b0001, sw_req=4'b0100 → grant ch2. With dack_en=1, DACK=4'b0100.
- No preemption and disable: grant ch3, then raise ch0 DREQ and set cmd_reg[2] → grant stays ch3 until cycle_done, then VALID_DREQ stays 0 while disabled.
- Async reset mid-grant: drop RESET_N between edges during ARB_GRANT with dack_en=1 → VALID_DREQ=0 and DACK inactive before the next CLK edge.
